lockout_controller: RTL and testbench

LOCKOUT_CONTROLLER -- requirements
Module: lockout_controller

---
 rtl/lockout_controller.sv | 103 ++++++++++
 tb/tb_lockout_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lockout_controller.sv
// Gates key pulses to the lock FSM and enforces a timed lockout after MAX_ATTEMPTS failed entries.
// Latency: key path 1 cycle; no backpressure, keys arriving while locked out are dropped.
module lockout_controller #(
  parameter int NUM_KEYS        = 4,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int CLOCK_FREQ      = 50000000,
  parameter int LOCKOUT_SECONDS = 30
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                error_flag,
  input  logic                lock_flag,
  output logic [NUM_KEYS-1:0] key_out,
  output logic                fsm_clear,
  output logic                lockout,
  output logic [3:0]          attempts_left,
  output logic [7:0]          seconds_left
);

  localparam int            PW         = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_FREQ - 1);
  localparam logic [3:0]    ATT_MAX    = 4'(MAX_ATTEMPTS);
  localparam logic [7:0]    SEC_INIT   = 8'(LOCKOUT_SECONDS);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    LOCKOUT = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          error_q;
  logic          lock_q;
  logic          err_rise;
  logic          unlock_fall;

  assign err_rise    = error_flag & ~error_q;
  assign unlock_fall = ~lock_flag & lock_q;

  // attempts_left is itself the failure counter, counting down from ATT_MAX
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ARMED;
      presc         <= '0;
      error_q       <= 1'b0;
      lock_q        <= 1'b0;
      key_out       <= '0;
      fsm_clear     <= 1'b0;
      lockout       <= 1'b0;
      attempts_left <= ATT_MAX;
      seconds_left  <= '0;
    end else begin
      error_q <= error_flag;
      lock_q  <= lock_flag;
      case (state)
        ARMED: begin
          key_out <= key_in;
          if (err_rise) begin
            attempts_left <= attempts_left - 4'd1;
            if (attempts_left == 4'd1) begin
              state        <= LOCKOUT;
              lockout      <= 1'b1;
              seconds_left <= SEC_INIT;
              presc        <= '0;
              key_out      <= '0;
            end
          end else if (unlock_fall) begin
            attempts_left <= ATT_MAX;
          end
        end
        LOCKOUT: begin
          key_out <= '0;
          if (presc == PRESC_LAST) begin
            presc        <= '0;
            seconds_left <= seconds_left - 8'd1;
            if (seconds_left == 8'd1) begin
              state     <= RELEASE;
              fsm_clear <= 1'b1;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        RELEASE: begin
          key_out       <= '0;
          fsm_clear     <= 1'b0;
          lockout       <= 1'b0;
          attempts_left <= ATT_MAX;
          state         <= ARMED;
        end
        default: begin
          state     <= ARMED;
          key_out   <= '0;
          fsm_clear <= 1'b0;
          lockout   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lockout_controller.sv
// Bench for lockout_controller: cycle-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_lockout_controller;

  localparam int NK   = 4;
  localparam int MAXA = 3;
  localparam int FREQ = 4;
  localparam int SECS = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NK-1:0] key_in = '0;
  logic          error_flag = 1'b0;
  logic          lock_flag = 1'b0;
  logic [NK-1:0] key_out;
  logic          fsm_clear;
  logic          lockout;
  logic [3:0]    attempts_left;
  logic [7:0]    seconds_left;

  int checks = 0;
  int errors = 0;

  lockout_controller #(
    .NUM_KEYS(NK), .MAX_ATTEMPTS(MAXA), .CLOCK_FREQ(FREQ), .LOCKOUT_SECONDS(SECS)
  ) dut (
    .clock(clock), .reset(reset), .key_in(key_in), .error_flag(error_flag),
    .lock_flag(lock_flag), .key_out(key_out), .fsm_clear(fsm_clear),
    .lockout(lockout), .attempts_left(attempts_left), .seconds_left(seconds_left)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=armed 1=locked 2=release; lock time tracked as elapsed cycles
  int            m_mode = 0;
  int            m_fails = 0;
  int            m_elapsed = 0;
  logic [NK-1:0] m_key = '0;
  logic          m_perr = 1'b0;
  logic          m_plock = 1'b0;

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_mode = 0; m_fails = 0; m_elapsed = 0; m_key = '0; m_perr = 1'b0; m_plock = 1'b0;
    end else begin
      bit rise, fall;
      rise = error_flag && !m_perr;
      fall = !lock_flag && m_plock;
      if (m_mode == 0) begin
        m_key = key_in;
        if (rise) begin
          m_fails++;
          if (m_fails == MAXA) begin
            m_mode = 1; m_elapsed = 0; m_key = '0;
          end
        end else if (fall) begin
          m_fails = 0;
        end
      end else if (m_mode == 1) begin
        m_key = '0;
        m_elapsed++;
        if (m_elapsed == SECS * FREQ) m_mode = 2;
      end else begin
        m_key = '0; m_fails = 0; m_mode = 0;
      end
      m_perr  = error_flag;
      m_plock = lock_flag;
    end
  end

  initial forever begin
    @(negedge clock);
    chk("key_out", int'(key_out), int'(m_key));
    chk("fsm_clear", int'(fsm_clear), (m_mode == 2) ? 1 : 0);
    chk("lockout", int'(lockout), (m_mode != 0) ? 1 : 0);
    chk("attempts_left", int'(attempts_left), MAXA - m_fails);
    chk("seconds_left", int'(seconds_left), (m_mode == 1) ? SECS - m_elapsed / FREQ : 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_attempts", int'(attempts_left), 3);
    chk("rst_lockout", int'(lockout), 0);
    chk("rst_seconds", int'(seconds_left), 0);
    reset = 1'b1;

    // pass-through
    @(negedge clock); key_in = 4'b0100;
    @(negedge clock); chk("pass_key", int'(key_out), 4); key_in = '0;
    @(negedge clock); chk("pass_width", int'(key_out), 0);

    // three failures, key dropped in trigger cycle
    error_flag = 1'b1;
    @(negedge clock); error_flag = 1'b0; chk("att_after1", int'(attempts_left), 2);
    @(negedge clock); error_flag = 1'b1;
    @(negedge clock); error_flag = 1'b0; chk("att_after2", int'(attempts_left), 1);
    @(negedge clock); error_flag = 1'b1; key_in = 4'b0001;
    @(negedge clock); error_flag = 1'b0; key_in = '0;
    chk("att_after3", int'(attempts_left), 0);
    chk("lock_entry", int'(lockout), 1);
    chk("sec_entry", int'(seconds_left), 3);
    chk("trigger_key_drop", int'(key_out), 0);

    // countdown with blocked inputs
    for (int k = 1; k <= 13; k++) begin
      @(negedge clock);
      if (k == 4) chk("sec_k4", int'(seconds_left), 2);
      if (k == 7) chk("sec_k7", int'(seconds_left), 2);
      if (k == 8) chk("sec_k8", int'(seconds_left), 1);
      if (k == 9) chk("blocked_att", int'(attempts_left), 0);
      if (k == 11) chk("sec_k11", int'(seconds_left), 1);
      if (k == 12) begin
        chk("release_clear", int'(fsm_clear), 1);
        chk("release_lockout", int'(lockout), 1);
        chk("release_sec", int'(seconds_left), 0);
      end
      if (k == 13) begin
        chk("armed_clear", int'(fsm_clear), 0);
        chk("armed_lockout", int'(lockout), 0);
        chk("armed_att", int'(attempts_left), 3);
      end
      error_flag = (k == 1 || k == 5);
      key_in     = (k == 1 || k == 6) ? 4'b1111 : 4'b0000;
      lock_flag  = (k == 5);
    end

    // success clearing
    @(negedge clock); error_flag = 1'b1;
    @(negedge clock); error_flag = 1'b0;
    @(negedge clock); error_flag = 1'b1;
    @(negedge clock); error_flag = 1'b0; chk("two_errors", int'(attempts_left), 1); lock_flag = 1'b1;
    @(negedge clock); lock_flag = 1'b0;
    @(negedge clock); chk("unlock_clear", int'(attempts_left), 3);

    // coincident error rise and unlock fall
    error_flag = 1'b1;
    @(negedge clock); error_flag = 1'b0; chk("coin_pre", int'(attempts_left), 2); lock_flag = 1'b1;
    @(negedge clock); error_flag = 1'b1; lock_flag = 1'b0;
    @(negedge clock); error_flag = 1'b0; chk("coincident", int'(attempts_left), 1);

    // re-enter lockout, then async reset between edges
    @(negedge clock); error_flag = 1'b1;
    @(negedge clock); error_flag = 1'b0; chk("relock", int'(lockout), 1);
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("arst_lockout", int'(lockout), 0);
    chk("arst_seconds", int'(seconds_left), 0);
    chk("arst_attempts", int'(attempts_left), 3);
    chk("arst_clear", int'(fsm_clear), 0);

    // error already high when reset releases counts as a rise
    @(negedge clock); error_flag = 1'b1;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); chk("rise_after_reset", int'(attempts_left), 2); error_flag = 1'b0;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
